ex_unit: RTL and testbench



---
 rtl/ops_pkg.sv | 61 ++++++
 rtl/ex_unit_if.sv | 31 +++
 rtl/ex_divider.sv | 85 ++++++++
 rtl/ex_unit.sv | 153 +++++++++++++++
 tb/tb_ex_unit.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ops_pkg.sv
// Shared execute-stage definitions: operation classes, op codes, FSM states and
// divider helpers. Also imported by the decoder.
package ops_pkg;

  localparam int unsigned DataWidth    = 32;
  localparam int unsigned RegAddrWidth = 5;

  typedef logic [DataWidth-1:0]    data_t;
  typedef logic [RegAddrWidth-1:0] reg_addr_t;

  typedef enum logic [2:0] {
    SelNop   = 3'b000,
    SelLogic = 3'b001,
    SelShift = 3'b010,
    SelArith = 3'b011,
    SelDiv   = 3'b100
  } alu_sel_e;

  localparam logic [7:0] OpOr   = 8'h25;
  localparam logic [7:0] OpAnd  = 8'h24;
  localparam logic [7:0] OpXor  = 8'h26;
  localparam logic [7:0] OpNor  = 8'h27;
  localparam logic [7:0] OpSll  = 8'h7C;
  localparam logic [7:0] OpSrl  = 8'h02;
  localparam logic [7:0] OpSra  = 8'h03;
  localparam logic [7:0] OpAddu = 8'h21;
  localparam logic [7:0] OpSubu = 8'h23;
  localparam logic [7:0] OpSlt  = 8'h2A;
  localparam logic [7:0] OpSltu = 8'h2B;
  localparam logic [7:0] OpDiv  = 8'h1A;
  localparam logic [7:0] OpDivu = 8'h1B;

  typedef enum logic [1:0] {
    StIdle,
    StDivRun,
    StDivDone
  } ex_state_e;

  typedef struct packed {
    data_t rem;
    data_t quo;
  } div_acc_t;

  function automatic data_t neg_if(input data_t v, input logic neg);
    return neg ? -v : v;
  endfunction

  // One restoring shift-subtract step: shifts the next dividend bit into the
  // partial remainder and retires one quotient bit.
  function automatic div_acc_t div_step(input div_acc_t acc, input data_t dvs);
    logic [DataWidth:0] shifted;
    logic               borrow;
    div_acc_t           res;
    shifted  = {acc.rem, acc.quo[DataWidth-1]};
    borrow   = shifted < {1'b0, dvs};
    res.quo  = {acc.quo[DataWidth-2:0], ~borrow};
    res.rem  = borrow ? shifted[DataWidth-1:0] : DataWidth'(shifted - {1'b0, dvs});
    return res;
  endfunction

endpackage

// File: rtl/ex_unit_if.sv
// Decode -> execute issue bundle plus the registered write-back and HI/LO view.
interface ex_unit_if;
  import ops_pkg::*;

  logic      flush;
  logic      in_valid;
  logic      in_ready;
  logic [7:0] alu_op;
  logic [2:0] alu_sel;
  data_t     src_data1;
  data_t     src_data2;
  reg_addr_t wr_addr;
  logic      wr_en;
  logic      wb_valid;
  logic      wb_en;
  reg_addr_t wb_addr;
  data_t     wb_data;
  data_t     hi;
  data_t     lo;

  modport master (
    output flush, in_valid, alu_op, alu_sel, src_data1, src_data2, wr_addr, wr_en,
    input  in_ready, wb_valid, wb_en, wb_addr, wb_data, hi, lo
  );

  modport slave (
    input  flush, in_valid, alu_op, alu_sel, src_data1, src_data2, wr_addr, wr_en,
    output in_ready, wb_valid, wb_en, wb_addr, wb_data, hi, lo
  );

endinterface

// File: rtl/ex_divider.sv
// Iterative radix-2 restoring divider with signed/unsigned modes and a
// divide-by-zero fast path. The first step is taken on the start cycle.
module ex_divider
  import ops_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  start,
  input  logic  signed_op,
  input  data_t dividend,
  input  data_t divisor,
  input  logic  abort,
  output logic  done,
  output data_t quotient,
  output data_t remainder
);

  localparam logic [5:0] CntLast = 6'(DIV_CYCLES);

  div_acc_t   acc_q, acc_d;
  data_t      dvs_q, dvs_d;
  logic [5:0] cnt_q, cnt_d;
  logic       neg_quo_q, neg_quo_d;
  logic       neg_rem_q, neg_rem_d;

  logic  dividend_neg, divisor_neg;
  data_t dividend_mag, divisor_mag;

  assign dividend_neg = signed_op & dividend[DataWidth-1];
  assign divisor_neg  = signed_op & divisor[DataWidth-1];
  assign dividend_mag = neg_if(dividend, dividend_neg);
  assign divisor_mag  = neg_if(divisor, divisor_neg);

  always_comb begin
    acc_d     = acc_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (abort) begin
      cnt_d = '0;
    end else if (start) begin
      if (divisor == '0) begin
        // Result is architecturally defined; skip the loop entirely.
        acc_d.quo = '1;
        acc_d.rem = dividend;
        cnt_d     = CntLast;
        neg_quo_d = 1'b0;
        neg_rem_d = 1'b0;
      end else begin
        acc_d     = div_step({{DataWidth{1'b0}}, dividend_mag}, divisor_mag);
        dvs_d     = divisor_mag;
        cnt_d     = 6'd1;
        neg_quo_d = dividend_neg ^ divisor_neg;
        neg_rem_d = dividend_neg;
      end
    end else if (cnt_q != '0 && cnt_q < CntLast) begin
      acc_d = div_step(acc_q, dvs_q);
      cnt_d = cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign done      = (cnt_q == CntLast);
  assign quotient  = neg_if(acc_q.quo, neg_quo_q);
  assign remainder = neg_if(acc_q.rem, neg_rem_q);

endmodule

// File: rtl/ex_unit.sv
// Execute stage: single-cycle ALU, divide sequencing FSM, registered
// write-back bundle and architectural HI/LO.
module ex_unit
  import ops_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input logic       clk,
  input logic       reset,
  ex_unit_if.slave  bus
);

  ex_state_e state_q, state_d;
  logic      in_ready_q;
  logic      wb_valid_q, wb_valid_d;
  logic      wb_en_q, wb_en_d;
  reg_addr_t wb_addr_q, wb_addr_d;
  data_t     wb_data_q, wb_data_d;
  data_t     hi_q, hi_d;
  data_t     lo_q, lo_d;

  data_t      alu_result;
  logic       alu_known;
  logic [4:0] shamt;
  logic       accept, is_div, div_start, div_abort, div_done;
  data_t      div_quo, div_rem;

  assign accept    = bus.in_valid && in_ready_q && !bus.flush;
  assign is_div    = (bus.alu_sel == SelDiv) && (bus.alu_op == OpDiv || bus.alu_op == OpDivu);
  assign div_start = accept && is_div;
  assign div_abort = bus.flush && (state_q == StDivRun);
  assign shamt     = bus.src_data1[4:0];

  always_comb begin
    alu_result = '0;
    alu_known  = 1'b1;
    case (bus.alu_sel)
      SelLogic: begin
        case (bus.alu_op)
          OpOr:    alu_result = bus.src_data1 | bus.src_data2;
          OpAnd:   alu_result = bus.src_data1 & bus.src_data2;
          OpXor:   alu_result = bus.src_data1 ^ bus.src_data2;
          OpNor:   alu_result = ~(bus.src_data1 | bus.src_data2);
          default: alu_known  = 1'b0;
        endcase
      end
      SelShift: begin
        case (bus.alu_op)
          OpSll:   alu_result = bus.src_data2 << shamt;
          OpSrl:   alu_result = bus.src_data2 >> shamt;
          OpSra:   alu_result = data_t'($signed(bus.src_data2) >>> shamt);
          default: alu_known  = 1'b0;
        endcase
      end
      SelArith: begin
        case (bus.alu_op)
          OpAddu:  alu_result = bus.src_data1 + bus.src_data2;
          OpSubu:  alu_result = bus.src_data1 - bus.src_data2;
          OpSlt:   alu_result = {{(DataWidth-1){1'b0}},
                                 $signed(bus.src_data1) < $signed(bus.src_data2)};
          OpSltu:  alu_result = {{(DataWidth-1){1'b0}}, bus.src_data1 < bus.src_data2};
          default: alu_known  = 1'b0;
        endcase
      end
      default: alu_known = 1'b0;
    endcase
  end

  ex_divider #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_divider (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .signed_op (bus.alu_op == OpDiv),
    .dividend  (bus.src_data1),
    .divisor   (bus.src_data2),
    .abort     (div_abort),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d    = state_q;
    wb_valid_d = 1'b0;
    wb_en_d    = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_div) begin
            state_d = (bus.src_data2 == '0) ? StDivDone : StDivRun;
          end else begin
            // Unknown ops and the NOP class retire as a bubble that writes nothing.
            wb_valid_d = 1'b1;
            wb_en_d    = bus.wr_en && alu_known;
            wb_addr_d  = bus.wr_addr;
            wb_data_d  = alu_known ? alu_result : '0;
          end
        end
      end
      StDivRun: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else if (div_done) begin
          state_d = StDivDone;
        end
      end
      StDivDone: begin
        hi_d       = div_rem;
        lo_d       = div_quo;
        wb_valid_d = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      in_ready_q <= 1'b1;
      wb_valid_q <= 1'b0;
      wb_en_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == StIdle);
      wb_valid_q <= wb_valid_d;
      wb_en_q    <= wb_en_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_en    = wb_en_q;
  assign bus.wb_addr  = wb_addr_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_ex_unit.sv
// Directed bench for ex_unit: expected write-backs are queued at issue and
// matched against each wb_valid beat by a negedge monitor.
module tb_ex_unit;
  import ops_pkg::*;

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        is_div;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n;
  exp_t sb[$];
  exp_t mon_e;

  ex_unit_if bus ();

  ex_unit #(
    .DIV_CYCLES (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] addr, input logic en);
    bus.in_valid  = 1'b1;
    bus.alu_sel   = sel;
    bus.alu_op    = op;
    bus.src_data1 = a;
    bus.src_data2 = b;
    bus.wr_addr   = addr;
    bus.wr_en     = en;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic push_wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    exp_t e;
    e.en = en; e.addr = addr; e.data = data; e.is_div = 1'b0; e.hi = '0; e.lo = '0;
    sb.push_back(e);
  endtask

  task automatic push_div(input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.en = 1'b0; e.addr = '0; e.data = '0; e.is_div = 1'b1; e.hi = hi; e.lo = lo;
    sb.push_back(e);
  endtask

  // Single-cycle op: accepted on the next edge, result checked by the monitor.
  task automatic issue(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] addr, input logic en,
                       input logic exp_en, input logic [31:0] exp_data);
    drive(sel, op, a, b, addr, en);
    push_wb(exp_en, addr, exp_data);
    step();
  endtask

  // Counts negedges with in_ready low; bounded so a stuck DUT still finishes.
  task automatic wait_ready(output int cycles);
    cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) break;
      cycles++;
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.wb_valid === 1'b1) begin
      checks++;
      assert (sb.size() != 0)
      else begin
        errors++;
        $error("FAIL wb_unexpected: observed wb_valid=1 expected no write-back");
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("wb_en", 32'(bus.wb_en), 32'(mon_e.en));
        if (mon_e.is_div) begin
          check("div_hi", bus.hi, mon_e.hi);
          check("div_lo", bus.lo, mon_e.lo);
        end else begin
          check("wb_addr", 32'(bus.wb_addr), 32'(mon_e.addr));
          check("wb_data", bus.wb_data, mon_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.alu_sel = '0;
    bus.alu_op = '0;
    bus.src_data1 = '0;
    bus.src_data2 = '0;
    bus.wr_addr = '0;
    bus.wr_en = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_wb_en", 32'(bus.wb_en), 32'd0);
    check("rst_wb_addr", 32'(bus.wb_addr), 32'd0);
    check("rst_wb_data", bus.wb_data, 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    reset = 1'b0;

    // Back-to-back single-cycle ops.
    issue(SelLogic, OpOr, 32'h0000_1100, 32'h0000_F0F0, 5'd3, 1'b1, 1'b1, 32'h0000_F1F0);
    issue(SelLogic, OpAnd, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd4, 1'b1, 1'b1, 32'h0F00_0F00);
    issue(SelLogic, OpXor, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd5, 1'b1, 1'b1, 32'hF00F_F00F);
    issue(SelLogic, OpNor, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd6, 1'b0, 1'b0, 32'h00F0_00F0);
    issue(SelShift, OpSra, 32'd4, 32'h8000_0000, 5'd7, 1'b1, 1'b1, 32'hF800_0000);
    issue(SelShift, OpSll, 32'h0000_0024, 32'd1, 5'd8, 1'b1, 1'b1, 32'h0000_0010);
    issue(SelShift, OpSrl, 32'd8, 32'h8000_0000, 5'd9, 1'b1, 1'b1, 32'h0080_0000);
    issue(SelArith, OpSlt, 32'hFFFF_FFFF, 32'd1, 5'd10, 1'b1, 1'b1, 32'd1);
    issue(SelArith, OpSltu, 32'hFFFF_FFFF, 32'd1, 5'd11, 1'b1, 1'b1, 32'd0);
    issue(SelArith, OpAddu, 32'hFFFF_FFFF, 32'd2, 5'd12, 1'b1, 1'b1, 32'd1);
    issue(SelArith, OpSubu, 32'd1, 32'd2, 5'd13, 1'b1, 1'b1, 32'hFFFF_FFFF);

    // Idle cycle: no write-back, data held.
    idle();
    step();
    @(negedge clk);
    check("idle_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("idle_wb_en", 32'(bus.wb_en), 32'd0);
    check("idle_wb_data_hold", bus.wb_data, 32'hFFFF_FFFF);

    issue(SelNop, 8'h21, 32'd1, 32'd2, 5'd14, 1'b1, 1'b0, 32'd0);
    issue(SelLogic, 8'h55, 32'd1, 32'd2, 5'd15, 1'b1, 1'b0, 32'd0);

    // DIVU with an ADDU held behind it.
    drive(SelDiv, OpDivu, 32'd100, 32'd7, 5'd1, 1'b1);
    push_div(32'd2, 32'd14);
    step();
    drive(SelArith, OpAddu, 32'd10, 32'd20, 5'd16, 1'b1);
    push_wb(1'b1, 5'd16, 32'd30);
    wait_ready(n);
    check("divu_busy_cycles", 32'(n), 32'd33);
    check("divu_hi", bus.hi, 32'd2);
    check("divu_lo", bus.lo, 32'd14);
    step();
    idle();
    step();

    drive(SelDiv, OpDiv, 32'hFFFF_FFF9, 32'd2, 5'd1, 1'b1);
    push_div(32'hFFFF_FFFF, 32'hFFFF_FFFD);
    step();
    idle();
    wait_ready(n);
    check("div_neg_busy_cycles", 32'(n), 32'd33);
    check("div_neg_lo", bus.lo, 32'hFFFF_FFFD);

    drive(SelDiv, OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 1'b1);
    push_div(32'd0, 32'h8000_0000);
    step();
    idle();
    wait_ready(n);
    check("div_min_hi", bus.hi, 32'd0);
    check("div_min_lo", bus.lo, 32'h8000_0000);

    // Divide by zero takes the short path.
    drive(SelDiv, OpDiv, 32'd5, 32'd0, 5'd1, 1'b1);
    push_div(32'd5, 32'hFFFF_FFFF);
    step();
    idle();
    wait_ready(n);
    check("divz_busy_cycles", 32'(n), 32'd1);
    check("divz_hi", bus.hi, 32'd5);
    check("divz_lo", bus.lo, 32'hFFFF_FFFF);

    // Flush at cycle 10 of a DIVU: no write-back, HI/LO untouched.
    drive(SelDiv, OpDivu, 32'd1000, 32'd3, 5'd1, 1'b1);
    step();
    idle();
    repeat (9) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    check("flush_hi", bus.hi, 32'd5);
    check("flush_lo", bus.lo, 32'hFFFF_FFFF);
    repeat (40) step();
    check("flush_hi_late", bus.hi, 32'd5);
    check("flush_lo_late", bus.lo, 32'hFFFF_FFFF);

    // Flush beats accept in IDLE.
    drive(SelArith, OpAddu, 32'd1, 32'd1, 5'd4, 1'b1);
    bus.flush = 1'b1;
    step();
    idle();
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_drop_wb_valid", 32'(bus.wb_valid), 32'd0);

    // Reset in the middle of a divide.
    drive(SelDiv, OpDivu, 32'd100, 32'd7, 5'd1, 1'b1);
    step();
    idle();
    repeat (5) step();
    reset = 1'b1;
    step();
    @(negedge clk);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("mid_rst_wb_en", 32'(bus.wb_en), 32'd0);
    check("mid_rst_wb_addr", 32'(bus.wb_addr), 32'd0);
    check("mid_rst_wb_data", bus.wb_data, 32'd0);
    check("mid_rst_hi", bus.hi, 32'd0);
    check("mid_rst_lo", bus.lo, 32'd0);
    reset = 1'b0;
    issue(SelArith, OpAddu, 32'd2, 32'd3, 5'd7, 1'b1, 1'b1, 32'd5);
    idle();
    repeat (40) step();
    check("mid_rst_hi_after", bus.hi, 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
